// File: rtl/morra_move_driver.sv
// Scripted move source for the MorraCinese game: move FIFO, START beat, score tally.
// Optional referee cross-check enabled by defining MORRA_REF_CHECK_EN (adds ref_err).
module morra_move_driver #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic [1:0]                 cfg_p1,
  input  logic [1:0]                 cfg_p2,
  input  logic                       run,
  input  logic                       abort,
  input  logic                       mv_valid,
  output logic                       mv_ready,
  input  logic [1:0]                 mv_p1,
  input  logic [1:0]                 mv_p2,
  output logic [1:0]                 P1,
  output logic [1:0]                 P2,
  output logic                       START,
  input  logic [1:0]                 ROUND,
  input  logic [1:0]                 GAME,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 winner,
  output logic [CNT_W-1:0]           p1_wins,
  output logic [CNT_W-1:0]           p2_wins,
  output logic [CNT_W-1:0]           ties,
  output logic [CNT_W-1:0]           invalid,
  output logic                       underrun,
  output logic [$clog2(DEPTH):0]     fifo_count
`ifdef MORRA_REF_CHECK_EN
  ,
  output logic                       ref_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CFG,
    S_PLAY,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       winner_q, winner_d;
  logic             underrun_q, underrun_d;
  logic [CNT_W-1:0] p1w_q, p1w_d;
  logic [CNT_W-1:0] p2w_q, p2w_d;
  logic [CNT_W-1:0] tie_q, tie_d;
  logic [CNT_W-1:0] inv_q, inv_d;

  logic       empty, full, push, pop, start_m;
  logic [3:0] head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign mv_ready = !full;
  assign push     = mv_valid && !full;
  assign head     = mem_q[rd_ptr_q];
  assign start_m  = (state_q == S_IDLE) && run && !abort;

  // State register
  always_ff @(posedge clk) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (run) state_d = S_CFG;
        S_CFG:  state_d = S_PLAY;
        S_PLAY: if (inflight_q && GAME != 2'b00) state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    P1    = 2'b00;
    P2    = 2'b00;
    START = 1'b0;
    pop   = 1'b0;
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    unique case (state_q)
      S_CFG: begin
        START = 1'b1;
        P1    = cfg_p1;
        P2    = cfg_p2;
      end
      S_PLAY: begin
        pop = !empty && !abort;
        if (pop) begin
          P1 = head[3:2];
          P2 = head[1:0];
        end
      end
      default: ;
    endcase
  end

  // FIFO bookkeeping and score tally
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = pop && (state_d == S_PLAY);
    winner_d   = winner_q;
    underrun_d = underrun_q;
    p1w_d      = p1w_q;
    p2w_d      = p2w_q;
    tie_d      = tie_q;
    inv_d      = inv_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (start_m) begin
      winner_d   = 2'b00;
      underrun_d = 1'b0;
      p1w_d      = '0;
      p2w_d      = '0;
      tie_d      = '0;
      inv_d      = '0;
    end else begin
      if (state_q == S_PLAY && empty) underrun_d = 1'b1;
      if (state_q == S_PLAY && state_d == S_DONE) winner_d = GAME;
      if (inflight_q) begin
        unique case (ROUND)
          2'b01:   p1w_d = sat_inc(p1w_q);
          2'b10:   p2w_d = sat_inc(p2w_q);
          2'b11:   tie_d = sat_inc(tie_q);
          default: inv_d = sat_inc(inv_q);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      winner_q   <= 2'b00;
      underrun_q <= 1'b0;
      p1w_q      <= '0;
      p2w_q      <= '0;
      tie_q      <= '0;
      inv_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      winner_q   <= winner_d;
      underrun_q <= underrun_d;
      p1w_q      <= p1w_d;
      p2w_q      <= p2w_d;
      tie_q      <= tie_d;
      inv_q      <= inv_d;
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {mv_p1, mv_p2};
  end

  assign winner     = winner_q;
  assign underrun   = underrun_q;
  assign p1_wins    = p1w_q;
  assign p2_wins    = p2w_q;
  assign ties       = tie_q;
  assign invalid    = inv_q;
  assign fifo_count = count_q;

`ifdef MORRA_REF_CHECK_EN
  logic [3:0] pair_q, pair_d;
  logic       ref_err_q, ref_err_d;

  function automatic logic [1:0] referee(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    r = 2'b10;
    unique case (1'b1)
      (a == 2'b00 || b == 2'b00): r = 2'b00;
      (a == b):                   r = 2'b11;
      (a == 2'b01 && b == 2'b11),
      (a == 2'b11 && b == 2'b10),
      (a == 2'b10 && b == 2'b01): r = 2'b01;
      default:                    r = 2'b10;
    endcase
    return r;
  endfunction

  always_comb begin
    pair_d    = pop ? head : pair_q;
    ref_err_d = ref_err_q;
    if (inflight_q && ROUND != referee(pair_q[3:2], pair_q[1:0]))
      ref_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      pair_q    <= 4'h0;
      ref_err_q <= 1'b0;
    end else begin
      pair_q    <= pair_d;
      ref_err_q <= ref_err_d;
    end
  end

  assign ref_err = ref_err_q;
`endif

endmodule

// File: tb/tb_morra_move_driver.sv
// Directed bench for morra_move_driver with a small registered game model.
// Build with MORRA_REF_CHECK_EN to also exercise the referee checker.
module tb_morra_move_driver;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic RST, run, abort, mv_valid, mv_ready;
  logic [1:0] cfg_p1, cfg_p2, mv_p1, mv_p2;
  logic [1:0] P1, P2, ROUND, GAME, winner;
  logic START, busy, done, underrun;
  logic [CNT_W-1:0] p1_wins, p2_wins, ties, invalid;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef MORRA_REF_CHECK_EN
  logic ref_err;
`endif

  int checks = 0;
  int failures = 0;

  // Game model knobs
  int   end_at = 0;
  logic [1:0] end_val = 2'b00;
  logic flip = 1'b0;
  int   mv_n = 0;

  always #5 clk = ~clk;

  morra_move_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .RST(RST), .cfg_p1(cfg_p1), .cfg_p2(cfg_p2),
    .run(run), .abort(abort), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_p1(mv_p1), .mv_p2(mv_p2), .P1(P1), .P2(P2), .START(START),
    .ROUND(ROUND), .GAME(GAME), .busy(busy), .done(done), .winner(winner),
    .p1_wins(p1_wins), .p2_wins(p2_wins), .ties(ties), .invalid(invalid),
    .underrun(underrun), .fifo_count(fifo_count)
`ifdef MORRA_REF_CHECK_EN
    , .ref_err(ref_err)
`endif
  );

  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    if (a == b) return 2'b11;
    if ((a == 2'b01 && b == 2'b11) || (a == 2'b11 && b == 2'b10) ||
        (a == 2'b10 && b == 2'b01)) return 2'b01;
    return 2'b10;
  endfunction

  // Registered game: answers one cycle after a move is presented
  always @(posedge clk) begin
    if (RST) begin
      ROUND <= 2'b00;
      GAME  <= 2'b00;
      mv_n  <= 0;
    end else if (START) begin
      ROUND <= 2'b00;
      GAME  <= 2'b00;
      mv_n  <= 0;
    end else begin
      ROUND <= flip ? 2'b10 : judge(P1, P2);
      GAME  <= 2'b00;
      if (P1 != 2'b00 || P2 != 2'b00) begin
        mv_n <= mv_n + 1;
        if (end_at != 0 && mv_n + 1 == end_at) GAME <= end_val;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] b);
    mv_valid = 1'b1;
    mv_p1 = a;
    mv_p2 = b;
    tick();
    mv_valid = 1'b0;
  endtask

  task automatic start_run;
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    RST = 1'b1; run = 1'b0; abort = 1'b0; mv_valid = 1'b0;
    mv_p1 = 2'b00; mv_p2 = 2'b00; cfg_p1 = 2'b01; cfg_p2 = 2'b10;
    do_reset();

    check("rst_busy", busy, 0);
    check("rst_start", START, 0);
    check("rst_p1p2", {P1, P2}, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", mv_ready, 1);
    check("rst_ctrs", {p1_wins, p2_wins, ties, invalid}, 0);
    check("rst_done_win", {done, winner, underrun}, 0);

    // 1: three P1 wins, game ends on the third
    push(2'b01, 2'b11);
    push(2'b10, 2'b01);
    push(2'b11, 2'b10);
    check("t1_count", fifo_count, 3);
    end_at = 3; end_val = 2'b01;
    start_run();
    check("t1_cfg_start", START, 1);
    check("t1_cfg_p1p2", {P1, P2}, 4'b0110);
    wait_done(n);
    check("t1_latency", n, 5);
    check("t1_p1_wins", p1_wins, 3);
    check("t1_other", {p2_wins, ties, invalid}, 0);
    check("t1_winner", winner, 2'b01);
    check("t1_busy", busy, 1);
    tick();
    check("t1_idle", {busy, done}, 0);
`ifdef MORRA_REF_CHECK_EN
    check("t1_ref_ok", ref_err, 0);
`endif

    // 2: two ties then draw
    push(2'b01, 2'b01);
    push(2'b10, 2'b10);
    end_at = 2; end_val = 2'b11;
    start_run();
    wait_done(n);
    check("t2_done", done, 1);
    check("t2_ties", ties, 2);
    check("t2_wins", {p1_wins, p2_wins}, 0);
    check("t2_winner", winner, 2'b11);
    tick();

    // 3: one move then underrun, game never ends
    push(2'b01, 2'b11);
    end_at = 0;
    start_run();
    tick();
    check("t3_mv1", {START, P1, P2}, 5'b0_0111);
    tick();
    check("t3_mv2_zero", {P1, P2}, 0);
    tick();
    check("t3_underrun", underrun, 1);
    check("t3_invalid", invalid, 0);
    check("t3_p1_wins", p1_wins, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_abort_idle", {busy, done}, 0);
    check("t3_abort_held", p1_wins, 1);

    // 4: overflow drop, then pop+push at 15
    do_reset();
    mv_valid = 1'b1; mv_p1 = 2'b01; mv_p2 = 2'b11;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    mv_valid = 1'b0;
    check("t4_full_count", fifo_count, DEPTH);
    check("t4_full_ready", mv_ready, 0);
    do_reset();
    mv_valid = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    mv_valid = 1'b0;
    check("t4_count15", fifo_count, 15);
    start_run();
    tick();
    mv_valid = 1'b1;
    tick();
    check("t4_pp_a", fifo_count, 15);
    tick();
    check("t4_pp_b", fifo_count, 15);
    mv_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_kept", {busy, fifo_count}, {1'b0, 5'd15});

    // 5: reset mid-PLAY
    do_reset();
    push(2'b01, 2'b11);
    push(2'b01, 2'b11);
    push(2'b01, 2'b11);
    start_run();
    tick();
    tick();
    tick();
    tick();
    check("t5_mid_wins", p1_wins, 2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t5_rst_out", {START, P1, P2, busy}, 0);
    check("t5_rst_fifo", fifo_count, 0);
    check("t5_rst_ctrs", {p1_wins, p2_wins, ties, invalid, underrun}, 0);

`ifdef MORRA_REF_CHECK_EN
    // 6: game returns wrong ROUND
    push(2'b01, 2'b11);
    push(2'b01, 2'b11);
    flip = 1'b1;
    start_run();
    tick();
    tick();
    check("t6_pre", ref_err, 0);
    tick();
    check("t6_err", ref_err, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    flip = 1'b0;
    tick();
    check("t6_sticky", ref_err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
